i2c_target_regs: RTL and testbench



---
 rtl/i2c_target_regs.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file, oversampled on the system clock.
// Supports pointer writes, auto-incrementing burst write/read and repeated START.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADR     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [3:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_MACK      = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [3:0] r_ptr;
    logic       r_rw;
    logic       r_mack;
    logic [7:0] r_regs [16];

    logic       w_s_scl;
    logic       w_s_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic [3:0] w_ptr_inc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_s_scl;
            r_sda_d    <= w_s_sda;
        end
    end

    assign w_s_scl    = r_scl_sync[SYNC_STAGES-1];
    assign w_s_sda    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_s_scl & ~r_scl_d;
    assign w_scl_fall = ~w_s_scl & r_scl_d;
    assign w_start    = w_s_scl & r_sda_d & ~w_s_sda;
    assign w_stop     = w_s_scl & ~r_sda_d & w_s_sda;
    assign w_byte     = {r_shift[6:0], w_s_sda};
    assign w_ptr_inc  = r_ptr + 4'd1;

    assign host_rdata = r_regs[host_addr];
    assign dbg_state  = r_state;

    // Bytes complete on the 8th rising edge; the ACK slot is entered on the
    // following falling edge so sda_oe only ever moves while SCL is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 4'd0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            sda_oe    <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= 4'd0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == S_PTR) begin
                                r_ptr   <= r_shift[3:0];
                                sda_oe  <= 1'b1;
                                r_state <= S_PTR_ACK;
                            end else if (r_shift[7:1] == TGT_ADR) begin
                                r_rw    <= r_shift[0];
                                sda_oe  <= 1'b1;
                                r_state <= S_ADDR_ACK;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_shift <= r_regs[r_ptr];
                                sda_oe  <= ~r_regs[r_ptr][7];
                                r_state <= S_RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= S_PTR;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe  <= 1'b0;
                            r_state <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_regs[r_ptr] <= w_byte;
                                wr_stb        <= 1'b1;
                                wr_addr       <= r_ptr;
                                wr_data       <= w_byte;
                                r_ptr         <= w_ptr_inc;
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            sda_oe    <= 1'b1;
                            r_state   <= S_WDATA_ACK;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            sda_oe    <= 1'b0;
                            r_state   <= S_MACK;
                        end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            sda_oe  <= ~r_shift[6];
                        end
                    end
                    S_MACK: begin
                        if (w_scl_rise) begin
                            r_mack <= w_s_sda;
                        end else if (w_scl_fall) begin
                            if (!r_mack) begin
                                r_ptr   <= w_ptr_inc;
                                r_shift <= r_regs[w_ptr_inc];
                                sda_oe  <= ~r_regs[w_ptr_inc][7];
                                r_state <= S_RDATA;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-level I2C controller drives the bus at 16x
// oversample while a register/pointer model predicts ACKs, read data and writes.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic [3:0] host_addr = 4'd0;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] host_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] dbg_state;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(.TGT_ADR(7'h42), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .scl_i      (scl_drv),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr = 4'd0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] e_item;
    logic [7:0]  tx [8];
    logic [7:0]  rx [8];
    bit          chk_oe = 1'b0;
    logic        exp_oe = 1'b0;
    bit          host_hold = 1'b0;
    logic [3:0]  host_fix = 4'd0;
    bit          prev_stb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            host_addr = host_hold ? host_fix : 4'($urandom_range(0, 15));
        end
    end

    // Scoreboard: pops expected writes, tracks the register model, checks
    // SDA drive and busy during SCL-high windows and host reads every cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            exp_q.delete();
            prev_stb = 1'b0;
        end else begin
            if (wr_stb) begin
                check("wr_stb_width", 32'(prev_stb), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_stb_unexpected: got addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
                end else begin
                    e_item = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e_item[11:8]));
                    check("wr_data", 32'(wr_data), 32'(e_item[7:0]));
                    m_regs[e_item[11:8]] = e_item[7:0];
                end
                obs_q.push_back({wr_addr, wr_data});
            end
            prev_stb = wr_stb;
            if (chk_oe) begin
                check("sda_oe", 32'(sda_oe), 32'(exp_oe));
                check("busy_in_xfer", 32'(busy), 1);
            end
            check("host_rdata", 32'(host_rdata), 32'(m_regs[host_addr]));
        end
    end

    task automatic bit_xfer(input logic cb, input logic eo, output logic line);
        wclk(2); sda_drv = cb;
        wclk(2); scl_drv = 1'b1;
        wclk(4); exp_oe = eo; chk_oe = 1'b1;
        wclk(2); line = sda_line;
        wclk(2); chk_oe = 1'b0; scl_drv = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_start();
        wclk(2); sda_drv = 1'b1;
        wclk(2); scl_drv = 1'b1;
        wclk(4); sda_drv = 1'b0;
        wclk(4); scl_drv = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop();
        wclk(2); sda_drv = 1'b0;
        wclk(2); scl_drv = 1'b1;
        wclk(4); sda_drv = 1'b1;
        wclk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        logic l;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, l);
        bit_xfer(1'b1, ack_exp, l);
        check("ack_line", 32'(l), 32'(!ack_exp));
    endtask

    task automatic recv_byte(input logic [7:0] exp_b, input logic drive, input logic mack, output logic [7:0] got);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, drive ? ~exp_b[i] : 1'b0, l);
            got[i] = l;
        end
        bit_xfer(mack ? 1'b0 : 1'b1, 1'b0, l);
        check("rd_byte", 32'(got), 32'(exp_b));
    endtask

    // START, address+W, then n bytes from tx[]; byte 0 sets the pointer.
    task automatic wr_body(input logic [6:0] a, input int n);
        logic match;
        match = (a == 7'h42);
        i2c_start();
        send_byte({a, 1'b0}, match);
        for (int j = 0; j < n; j++) begin
            if (match) begin
                if (j == 0) begin
                    m_ptr = tx[0][3:0];
                end else begin
                    exp_q.push_back({m_ptr, tx[j]});
                    m_ptr = m_ptr + 4'd1;
                end
            end
            send_byte(tx[j], match);
        end
    endtask

    task automatic rd_body(input logic [6:0] a, input int n);
        logic match;
        logic [7:0] got;
        match = (a == 7'h42);
        i2c_start();
        send_byte({a, 1'b1}, match);
        for (int j = 0; j < n; j++) begin
            recv_byte(match ? m_regs[m_ptr] : 8'hFF, match, j < n - 1, got);
            rx[j] = got;
            if (match && j < n - 1) m_ptr = m_ptr + 4'd1;
        end
    endtask

    task automatic finish_xact();
        i2c_stop();
        wclk(4);
        check("wr_q_drained", 32'(exp_q.size()), 0);
        check("busy_after_stop", 32'(busy), 0);
    endtask

    task automatic host_peek(input logic [3:0] a, input logic [7:0] exp_v, input string name);
        host_fix = a;
        host_hold = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(host_rdata), 32'(exp_v));
        host_hold = 1'b0;
    endtask

    initial begin
        int n_obs;
        int kind;
        int n;
        logic l;
        logic [6:0] a;

        wclk(3);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_wr_stb", 32'(wr_stb), 0);
        check("rst_busy", 32'(busy), 0);
        rstn = 1'b1;
        wclk(2);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_state_idle", 32'(dbg_state), 0);
        host_peek(4'd9, 8'h00, "rst_reg9");

        // Write burst with pointer 3.
        tx[0] = 8'h03; tx[1] = 8'hA5; tx[2] = 8'h5A;
        wr_body(7'h42, 3);
        finish_xact();
        check("burst_stb_count", 32'(obs_q.size()), 2);
        if (obs_q.size() == 2) begin
            check("burst_stb0", 32'(obs_q[0]), 32'h3A5);
            check("burst_stb1", 32'(obs_q[1]), 32'h45A);
        end
        host_peek(4'd3, 8'hA5, "host_reg3");
        host_peek(4'd4, 8'h5A, "host_reg4");

        // Write burst that wraps 15 -> 0.
        tx[0] = 8'hFF; tx[1] = 8'h3C; tx[2] = 8'hC3;
        wr_body(7'h42, 3);
        finish_xact();
        host_peek(4'd15, 8'h3C, "host_reg15");
        host_peek(4'd0, 8'hC3, "host_reg0");

        // Pointer 15, repeated START, read two bytes (wraps), NACK.
        tx[0] = 8'h0F;
        wr_body(7'h42, 1);
        rd_body(7'h42, 2);
        check("rd_wrap0", 32'(rx[0]), 32'h3C);
        check("rd_wrap1", 32'(rx[1]), 32'hC3);
        check("oe_after_nack", 32'(sda_oe), 0);
        finish_xact();

        // Foreign address: no ACK, no writes, busy still tracks the bus.
        n_obs = obs_q.size();
        tx[0] = 8'h01;
        wr_body(7'h48, 1);
        finish_xact();
        check("mismatch_no_stb", 32'(obs_q.size()), 32'(n_obs));

        // STOP after four data bits.
        tx[0] = 8'h02;
        wr_body(7'h42, 1);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, l);
        finish_xact();
        check("abort_no_stb", 32'(obs_q.size()), 32'(n_obs));
        check("abort_idle", 32'(dbg_state), 0);
        host_peek(4'd2, 8'h00, "abort_reg2");

        // Reset while the target pulls SDA for bit 6 of 0xA5.
        tx[0] = 8'h03;
        wr_body(7'h42, 1);
        i2c_start();
        send_byte(8'h85, 1'b1);
        bit_xfer(1'b1, 1'b0, l);
        wclk(2); sda_drv = 1'b1;
        wclk(2); scl_drv = 1'b1;
        wclk(4);
        check("oe_before_reset", 32'(sda_oe), 1);
        #2 rstn = 1'b0;
        m_ptr = 4'd0;
        #1 check("oe_async_reset", 32'(sda_oe), 0);
        check("busy_async_reset", 32'(busy), 0);
        wclk(1);
        for (int i = 0; i < 16; i++) host_peek(4'(i), 8'h00, "reset_reg_clear");
        wclk(2);
        rstn = 1'b1;
        wclk(4);
        check("post_reset_idle", 32'(dbg_state), 0);

        // Randomized transactions checked against the model.
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(2, 5);
                    for (int j = 0; j < n; j++) tx[j] = 8'($urandom_range(0, 255));
                    wr_body(7'h42, n);
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) begin
                        tx[0] = 8'($urandom_range(0, 255));
                        wr_body(7'h42, 1);
                    end
                    rd_body(7'h42, $urandom_range(1, 4));
                end
                2: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == 7'h42) a = 7'h43;
                    if ($urandom_range(0, 1) == 1) begin
                        tx[0] = 8'($urandom_range(0, 255));
                        tx[1] = 8'($urandom_range(0, 255));
                        wr_body(a, 2);
                    end else begin
                        rd_body(a, 2);
                    end
                end
                default: begin
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) tx[j] = 8'($urandom_range(0, 255));
                    wr_body(7'h42, n);
                    n = $urandom_range(1, 7);
                    for (int j = 0; j < n; j++) bit_xfer(1'($urandom_range(0, 1)), 1'b0, l);
                end
            endcase
            finish_xact();
        end

        wclk(10);
        check("final_idle", 32'(dbg_state), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
